// File: rtl/dbg_halt_ctrl.sv
// Debug halt/resume sequencer: stop fetch, drain, record cause/dpc, hold halted, resume or step.
// Latency: event -> flush/halt_fetch next cycle; halted one cycle after pipe_idle (or drain timeout).
// Backpressure: none; waits on pipe_idle in DRAIN, bounded by DRAIN_TMO cycles.
//
// Ports:
//   cpu_clk, cpu_rstn            clock, async active-low reset
//   haltreq/resumereq/dret       DM halt/resume requests and dret retirement
//   ebreak/breakpoint            debug-entering events from EX (ex_pc is their pc)
//   step/instr_retire            dcsr.step and retirement, used for single-step
//   pipe_idle, next_pc           pipeline empty flag and resume pc
//   halt_fetch, flush            fetch stall and EX-and-younger kill pulse
//   dbg_mode, halted, resumeack  debug status toward the core and DM
//   dpc_we/dpc_wdata             dpc write strobe and value
//   cause_we/cause               dcsr.cause write strobe and value
//   drain_timeout                sticky: last DRAIN ended by timeout
//
// Build option: define KRV_DBG_STEP_EN to build single-step (STEP state, cause 4).
// Without it, step and instr_retire are ignored and RESUME always returns to RUN.

module dbg_halt_ctrl #(
  parameter int PC_WIDTH  = 32,
  parameter int DRAIN_TMO = 31
) (
  input  logic                cpu_clk,
  input  logic                cpu_rstn,
  input  logic                haltreq,
  input  logic                resumereq,
  input  logic                step,
  input  logic                ebreak,
  input  logic                breakpoint,
  input  logic                dret,
  input  logic                instr_retire,
  input  logic                pipe_idle,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic [PC_WIDTH-1:0] next_pc,
  output logic                halt_fetch,
  output logic                flush,
  output logic                dbg_mode,
  output logic                halted,
  output logic                resumeack,
  output logic                dpc_we,
  output logic [PC_WIDTH-1:0] dpc_wdata,
  output logic                cause_we,
  output logic [2:0]          cause,
  output logic                drain_timeout
);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_STEP   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HALTED = 3'd3,
    ST_RESUME = 3'd4
  } state_e;

  localparam logic [5:0] TMO           = 6'(DRAIN_TMO);
  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_TRIGGER = 3'd2;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
`ifdef KRV_DBG_STEP_EN
  localparam logic [2:0] CAUSE_STEP    = 3'd4;
`endif

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic                halt_fetch_q, halt_fetch_d;
  logic                flush_q, flush_d;
  logic                dbg_mode_q, dbg_mode_d;
  logic                halted_q, halted_d;
  logic                resumeack_q, resumeack_d;
  logic                dpc_we_q, dpc_we_d;
  logic [PC_WIDTH-1:0] dpc_wdata_q, dpc_wdata_d;
  logic                cause_we_q, cause_we_d;
  logic [2:0]          cause_q, cause_d;
  logic                drain_timeout_q, drain_timeout_d;

  logic                exc_evt;     // breakpoint or ebreak: always flushes
  logic [2:0]          evt_cause;
  logic [PC_WIDTH-1:0] evt_pc;
  logic                drain_expired;
  logic                enter_drain;

`ifndef KRV_DBG_STEP_EN
  logic unused_step_inputs;
  assign unused_step_inputs = step ^ instr_retire;
`endif

  assign exc_evt       = breakpoint | ebreak;
  assign drain_expired = (cnt_q == TMO);

  // Priority encode the debug-entry cause; haltreq is the fallback.
  always_comb begin
    evt_cause = CAUSE_HALTREQ;
    evt_pc    = next_pc;
    if (breakpoint) begin
      evt_cause = CAUSE_TRIGGER;
      evt_pc    = ex_pc;
    end else if (ebreak) begin
      evt_cause = CAUSE_EBREAK;
      evt_pc    = ex_pc;
    end
  end

  // State register
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (exc_evt || haltreq) state_d = ST_DRAIN;
      end
`ifdef KRV_DBG_STEP_EN
      // haltreq is deliberately absent: the step completes with cause 4.
      ST_STEP: begin
        if (exc_evt || instr_retire) state_d = ST_DRAIN;
      end
`endif
      ST_DRAIN: begin
        if (pipe_idle || drain_expired) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (resumereq || dret) state_d = ST_RESUME;
      end
      ST_RESUME: begin
`ifdef KRV_DBG_STEP_EN
        state_d = step ? ST_STEP : ST_RUN;
`else
        state_d = ST_RUN;
`endif
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output logic: every output is registered, so its _d is derived from the
  // transition being taken this cycle.
  always_comb begin
    cnt_d           = '0;
    flush_d         = 1'b0;
    dpc_we_d        = 1'b0;
    cause_we_d      = 1'b0;
    cause_d         = cause_q;
    dpc_wdata_d     = dpc_wdata_q;
    drain_timeout_d = drain_timeout_q;
    enter_drain     = (state_d == ST_DRAIN) && (state_q != ST_DRAIN);

    if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) begin
      cnt_d = cnt_q + 6'd1;
    end

    // Cause/dpc latch only on DRAIN entry, so later events cannot overwrite.
    if (enter_drain) begin
      flush_d     = 1'b1;
      cause_d     = evt_cause;
      dpc_wdata_d = evt_pc;
`ifdef KRV_DBG_STEP_EN
      // Plain step completion: the retired instruction is gone, nothing to kill.
      if ((state_q == ST_STEP) && !exc_evt) begin
        flush_d     = 1'b0;
        cause_d     = CAUSE_STEP;
        dpc_wdata_d = next_pc;
      end
`endif
    end

    if ((state_q == ST_DRAIN) && (state_d == ST_HALTED)) begin
      dpc_we_d   = 1'b1;
      cause_we_d = 1'b1;
      // An idle pipe in the expiry cycle counts as a normal drain.
      if (!pipe_idle) drain_timeout_d = 1'b1;
    end

    if (state_d == ST_RESUME) drain_timeout_d = 1'b0;

    halt_fetch_d = (state_d == ST_DRAIN) || (state_d == ST_HALTED) || (state_d == ST_RESUME);
    dbg_mode_d   = (state_d == ST_HALTED);
    halted_d     = (state_d == ST_HALTED);
    resumeack_d  = (state_d == ST_RESUME);
  end

  // Output and counter registers
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      cnt_q           <= '0;
      halt_fetch_q    <= 1'b0;
      flush_q         <= 1'b0;
      dbg_mode_q      <= 1'b0;
      halted_q        <= 1'b0;
      resumeack_q     <= 1'b0;
      dpc_we_q        <= 1'b0;
      dpc_wdata_q     <= '0;
      cause_we_q      <= 1'b0;
      cause_q         <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      halt_fetch_q    <= halt_fetch_d;
      flush_q         <= flush_d;
      dbg_mode_q      <= dbg_mode_d;
      halted_q        <= halted_d;
      resumeack_q     <= resumeack_d;
      dpc_we_q        <= dpc_we_d;
      dpc_wdata_q     <= dpc_wdata_d;
      cause_we_q      <= cause_we_d;
      cause_q         <= cause_d;
      drain_timeout_q <= drain_timeout_d;
    end
  end

  assign halt_fetch    = halt_fetch_q;
  assign flush         = flush_q;
  assign dbg_mode      = dbg_mode_q;
  assign halted        = halted_q;
  assign resumeack     = resumeack_q;
  assign dpc_we        = dpc_we_q;
  assign dpc_wdata     = dpc_wdata_q;
  assign cause_we      = cause_we_q;
  assign cause         = cause_q;
  assign drain_timeout = drain_timeout_q;

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// Bench for dbg_halt_ctrl: directed debug scenarios, a per-cycle reference model,
// and hand-computed literal expectations at key cycles.
// Inputs change on the falling edge; outputs are compared on the falling edge.

module tb_dbg_halt_ctrl;

  localparam int PCW = 32;
  localparam int TMO = 31;
`ifdef KRV_DBG_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic           cpu_clk = 1'b0;
  logic           cpu_rstn = 1'b0;
  logic           haltreq = 1'b0, resumereq = 1'b0, step = 1'b0, ebreak = 1'b0;
  logic           breakpoint = 1'b0, dret = 1'b0, instr_retire = 1'b0, pipe_idle = 1'b1;
  logic [PCW-1:0] ex_pc = '0, next_pc = '0;
  logic           halt_fetch, flush, dbg_mode, halted, resumeack, dpc_we, cause_we, drain_timeout;
  logic [PCW-1:0] dpc_wdata;
  logic [2:0]     cause;

  int  total = 0;
  int  bad = 0;
  bit  chk_en = 1'b0;

  always #5 cpu_clk = ~cpu_clk;

  dbg_halt_ctrl #(.PC_WIDTH(PCW), .DRAIN_TMO(TMO)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .haltreq(haltreq), .resumereq(resumereq), .step(step), .ebreak(ebreak),
    .breakpoint(breakpoint), .dret(dret), .instr_retire(instr_retire),
    .pipe_idle(pipe_idle), .ex_pc(ex_pc), .next_pc(next_pc),
    .halt_fetch(halt_fetch), .flush(flush), .dbg_mode(dbg_mode), .halted(halted),
    .resumeack(resumeack), .dpc_we(dpc_we), .dpc_wdata(dpc_wdata),
    .cause_we(cause_we), .cause(cause), .drain_timeout(drain_timeout)
  );

  // ---------------- reference model ----------------
  // Phase of the debug sequence, plus the facts the spec says are remembered.
  localparam int P_RUN = 0, P_STEP = 1, P_DRAIN = 2, P_HALTED = 3, P_RESUME = 4;

  typedef struct {
    int          phase;
    int          drain_age;   // cycles already spent in DRAIN
    logic [2:0]  cause;
    logic [31:0] dpc;
    logic        timed_out;
    logic        flush_now;
    logic        first_halt;
    logic        ack_now;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t reset_model();
    mdl_t r;
    r.phase = P_RUN; r.drain_age = 0; r.cause = 3'd0; r.dpc = 32'd0;
    r.timed_out = 1'b0; r.flush_now = 1'b0; r.first_halt = 1'b0; r.ack_now = 1'b0;
    return r;
  endfunction

  function automatic mdl_t advance(mdl_t s);
    mdl_t n = s;
    n.flush_now = 1'b0; n.first_halt = 1'b0; n.ack_now = 1'b0;
    if (s.phase == P_RUN || s.phase == P_STEP) begin
      if (breakpoint || ebreak || (haltreq && s.phase == P_RUN)) begin
        n.cause = breakpoint ? 3'd2 : (ebreak ? 3'd1 : 3'd3);
        n.dpc   = (breakpoint || ebreak) ? ex_pc : next_pc;
        n.flush_now = 1'b1; n.phase = P_DRAIN; n.drain_age = 0;
      end else if (s.phase == P_STEP && instr_retire) begin
        n.cause = 3'd4; n.dpc = next_pc; n.phase = P_DRAIN; n.drain_age = 0;
      end
    end else if (s.phase == P_DRAIN) begin
      if (pipe_idle || s.drain_age == TMO) begin
        n.phase = P_HALTED; n.first_halt = 1'b1;
        if (!pipe_idle) n.timed_out = 1'b1;
      end else begin
        n.drain_age = s.drain_age + 1;
      end
    end else if (s.phase == P_HALTED) begin
      if (resumereq || dret) begin
        n.phase = P_RESUME; n.ack_now = 1'b1; n.timed_out = 1'b0;
      end
    end else begin
      n.phase = (STEP_EN && step) ? P_STEP : P_RUN;
    end
    return n;
  endfunction

  always @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) m <= reset_model();
    else           m <= advance(m);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge cpu_clk) begin
    if (chk_en && cpu_rstn) begin
      chk("cmp.halt_fetch", 32'(halt_fetch),
          32'(m.phase == P_DRAIN || m.phase == P_HALTED || m.phase == P_RESUME));
      chk("cmp.flush", 32'(flush), 32'(m.flush_now));
      chk("cmp.dbg_mode", 32'(dbg_mode), 32'(m.phase == P_HALTED));
      chk("cmp.halted", 32'(halted), 32'(m.phase == P_HALTED));
      chk("cmp.resumeack", 32'(resumeack), 32'(m.ack_now));
      chk("cmp.dpc_we", 32'(dpc_we), 32'(m.first_halt));
      chk("cmp.cause_we", 32'(cause_we), 32'(m.first_halt));
      chk("cmp.dpc_wdata", dpc_wdata, m.dpc);
      chk("cmp.cause", 32'(cause), 32'(m.cause));
      chk("cmp.drain_timeout", 32'(drain_timeout), 32'(m.timed_out));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    @(negedge cpu_clk);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.halt_fetch", 32'(halt_fetch), 32'd0);
    chk("rst.cause", 32'(cause), 32'd0);
    chk("rst.dpc", dpc_wdata, 32'd0);
    cpu_rstn = 1'b1;
    chk_en   = 1'b1;
    cyc(2);

    // haltreq with idle pipe: flush at +1, halted at +2
    next_pc = 32'h100; haltreq = 1'b1;
    cyc(1); haltreq = 1'b0;
    chk("hr.flush", 32'(flush), 32'd1);
    chk("hr.halt_fetch", 32'(halt_fetch), 32'd1);
    chk("hr.halted_early", 32'(halted), 32'd0);
    cyc(1);
    chk("hr.halted", 32'(halted), 32'd1);
    chk("hr.cause", 32'(cause), 32'd3);
    chk("hr.dpc", dpc_wdata, 32'h100);
    chk("hr.dpc_we", 32'(dpc_we), 32'd1);
    cyc(1);
    chk("hr.dpc_we_pulse", 32'(dpc_we), 32'd0);
    chk("hr.still_halted", 32'(halted), 32'd1);

    // resumereq: ack at R+1, fetch released at R+2
    resumereq = 1'b1;
    cyc(1); resumereq = 1'b0;
    chk("res.ack", 32'(resumeack), 32'd1);
    chk("res.dbg_mode", 32'(dbg_mode), 32'd0);
    chk("res.halt_fetch", 32'(halt_fetch), 32'd1);
    cyc(1);
    chk("res.ack_pulse", 32'(resumeack), 32'd0);
    chk("res.fetch_free", 32'(halt_fetch), 32'd0);
    cyc(2);

    // simultaneous breakpoint/ebreak/haltreq: trigger wins
    ex_pc = 32'h80; next_pc = 32'h300;
    breakpoint = 1'b1; ebreak = 1'b1; haltreq = 1'b1;
    cyc(1); breakpoint = 1'b0; ebreak = 1'b0; haltreq = 1'b0;
    chk("pri.flush", 32'(flush), 32'd1);
    cyc(1);
    chk("pri.halted", 32'(halted), 32'd1);
    chk("pri.cause", 32'(cause), 32'd2);
    chk("pri.dpc", dpc_wdata, 32'h80);

    // resume with step, retire at R+4
    step = 1'b1; resumereq = 1'b1;
    cyc(1); resumereq = 1'b0;
    chk("step.ack", 32'(resumeack), 32'd1);
    cyc(1);
    chk("step.fetch_free", 32'(halt_fetch), 32'd0);
    cyc(2);
    next_pc = 32'h204; instr_retire = 1'b1;
    cyc(1); instr_retire = 1'b0;
    chk("step.noflush", 32'(flush), 32'd0);
    cyc(1);
`ifdef KRV_DBG_STEP_EN
    chk("step.halted", 32'(halted), 32'd1);
    chk("step.cause", 32'(cause), 32'd4);
    chk("step.dpc", dpc_wdata, 32'h204);
`else
    chk("step.no_rehalt", 32'(halted), 32'd0);
    chk("step.cause_kept", 32'(cause), 32'd2);
    haltreq = 1'b1;
    cyc(1); haltreq = 1'b0;
    cyc(1);
`endif

    // resume with step, breakpoint plus haltreq right away
    resumereq = 1'b1;
    cyc(1); resumereq = 1'b0;
    cyc(1);
    ex_pc = 32'hA0; breakpoint = 1'b1; haltreq = 1'b1;
    cyc(1); breakpoint = 1'b0; haltreq = 1'b0;
    chk("stepbp.flush", 32'(flush), 32'd1);
    cyc(1);
    chk("stepbp.halted", 32'(halted), 32'd1);
    chk("stepbp.cause", 32'(cause), 32'd2);
    chk("stepbp.dpc", dpc_wdata, 32'hA0);
    step = 1'b0; resumereq = 1'b1;
    cyc(1); resumereq = 1'b0;
    cyc(3);

    // drain timeout: pipe never idles
    pipe_idle = 1'b0; next_pc = 32'h400; haltreq = 1'b1;
    cyc(1); haltreq = 1'b0;
    chk("tmo.drain", 32'(halt_fetch), 32'd1);
    cyc(31);
    chk("tmo.not_yet", 32'(halted), 32'd0);
    cyc(1);
    chk("tmo.halted", 32'(halted), 32'd1);
    chk("tmo.flag", 32'(drain_timeout), 32'd1);
    pipe_idle = 1'b1;
    cyc(2);
    resumereq = 1'b1;
    cyc(1); resumereq = 1'b0;
    chk("tmo.cleared", 32'(drain_timeout), 32'd0);
    cyc(2);

    // events during DRAIN and HALTED are ignored; then dret resumes
    pipe_idle = 1'b0; next_pc = 32'h140; haltreq = 1'b1;
    cyc(1); haltreq = 1'b0; ex_pc = 32'h90; ebreak = 1'b1;
    cyc(1); ebreak = 1'b0; pipe_idle = 1'b1;
    cyc(1);
    chk("ign.halted", 32'(halted), 32'd1);
    chk("ign.cause", 32'(cause), 32'd3);
    chk("ign.dpc", dpc_wdata, 32'h140);
    breakpoint = 1'b1; haltreq = 1'b1;
    cyc(1); breakpoint = 1'b0; haltreq = 1'b0;
    cyc(1);
    chk("ign.cause_hold", 32'(cause), 32'd3);
    chk("ign.no_rewrite", 32'(dpc_we), 32'd0);
    dret = 1'b1;
    cyc(1); dret = 1'b0;
    chk("dret.ack", 32'(resumeack), 32'd1);
    chk("dret.dbg_mode", 32'(dbg_mode), 32'd0);
    cyc(1);
    chk("dret.ack_once", 32'(resumeack), 32'd0);
    cyc(2);

    // resumereq and dret together: one acknowledge
    haltreq = 1'b1;
    cyc(1); haltreq = 1'b0;
    cyc(1);
    resumereq = 1'b1; dret = 1'b1;
    cyc(1); resumereq = 1'b0; dret = 1'b0;
    chk("both.ack", 32'(resumeack), 32'd1);
    cyc(1);
    chk("both.ack_once", 32'(resumeack), 32'd0);
    cyc(2);

    // async reset while halted
    next_pc = 32'h500; haltreq = 1'b1;
    cyc(1); haltreq = 1'b0;
    cyc(1);
    chk("arst.pre_halted", 32'(halted), 32'd1);
    #2 cpu_rstn = 1'b0;
    #1;
    chk("arst.halted", 32'(halted), 32'd0);
    chk("arst.dbg_mode", 32'(dbg_mode), 32'd0);
    chk("arst.halt_fetch", 32'(halt_fetch), 32'd0);
    chk("arst.cause", 32'(cause), 32'd0);
    chk("arst.dpc", dpc_wdata, 32'd0);
    @(negedge cpu_clk); cpu_rstn = 1'b1;
    cyc(1);
    chk("arst.no_dpc_we", 32'(dpc_we), 32'd0);
    chk("arst.run", 32'(halt_fetch), 32'd0);
    cyc(3);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
